uart_rx_flow_ctrl: RTL and testbench

- Controller for the buffered UART receive path, in the uart_clk domain beside the RX path.
- Three functions:
  - Drives the RTS hardware flow-control output with hysteresis on RX FIFO occupancy.
  - Runs a 16550-style character-timeout timer.
  - Generates RX-trigger and RX-timeout interrupt requests for the register file.
- Consumes write-side FIFO status and read events already synchronised into uart_clk.

---
 rtl/uart_rx_ctrl_pkg.sv | 16 +
 rtl/uart_rx_timeout_cnt.sv | 48 ++++
 rtl/uart_rx_flow_ctrl.sv | 102 ++++++++++
 tb/tb_uart_rx_flow_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and helpers for the UART receive-path flow controller.
package uart_rx_ctrl_pkg;

  typedef enum logic {RTS_RUN = 1'b0, RTS_HOLD = 1'b1} rts_state_t;

  localparam int unsigned MIN_CHAR_BITS = 7;
  localparam int unsigned MAX_CHAR_BITS = 12;

  // Frame length in bits: start + data(5..8) + optional parity + 1 or 2 stop.
  function automatic logic [3:0] char_bits(input logic [1:0] data_bits,
                                           input logic       parity_en,
                                           input logic       stop2);
    return 4'(MIN_CHAR_BITS) + {2'b00, data_bits} + {3'b000, parity_en} + {3'b000, stop2};
  endfunction

endpackage

// File: rtl/uart_rx_timeout_cnt.sv
// 16550-style character-timeout counter with sticky interrupt request.
module uart_rx_timeout_cnt #(
  parameter int unsigned TMO_W = 10
) (
  input  logic             uart_clk,
  input  logic             uart_rst_n,
  input  logic             i_fifo_reset,
  input  logic             i_clr_cnt,
  input  logic             i_clr_irq,
  input  logic             i_tick,
  input  logic             i_empty,
  input  logic [TMO_W-1:0] i_limit,
  output logic             o_irq
);

  logic [TMO_W-1:0] r_cnt;
  logic             r_irq;
  logic             w_reached;

  // A live limit change below the current count counts as reaching it.
  assign w_reached = (r_cnt >= i_limit);
  assign o_irq     = r_irq;

  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      r_cnt <= '0;
      r_irq <= 1'b0;
    end else if (i_fifo_reset) begin
      r_cnt <= '0;
      r_irq <= 1'b0;
    end else begin
      if (i_clr_cnt) begin
        r_cnt <= '0;
      end else if (r_cnt > i_limit) begin
        r_cnt <= i_limit;
      end else if (i_tick && (r_cnt < i_limit)) begin
        r_cnt <= r_cnt + TMO_W'(1);
      end

      if (i_clr_irq) begin
        r_irq <= 1'b0;
      end else if (w_reached && !i_empty) begin
        r_irq <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_flow_ctrl.sv
// RX flow control: RTS hysteresis FSM, trigger-level IRQ and character-timeout IRQ.
module uart_rx_flow_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned OVERSAMPLE_RATE = 16,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned LEVEL_W         = $clog2(FIFO_DEPTH) + 1,
  parameter int unsigned TIMEOUT_CHARS   = 4,
  parameter int unsigned TMO_W           = $clog2(TIMEOUT_CHARS * MAX_CHAR_BITS * OVERSAMPLE_RATE + 1)
) (
  input  logic               uart_clk,
  input  logic               uart_rst_n,
  input  logic               sample_tick,
  input  logic               rx_active,
  input  logic               rx_wr_pulse,
  input  logic [LEVEL_W-1:0] rx_level,
  input  logic               rx_empty_sync,
  input  logic               rd_pulse_sync,
  input  logic               fifo_reset_sync,
  input  logic               cfg_flow_en,
  input  logic [LEVEL_W-1:0] cfg_rts_hi,
  input  logic [LEVEL_W-1:0] cfg_rts_lo,
  input  logic [LEVEL_W-1:0] cfg_trig_level,
  input  logic [1:0]         cfg_data_bits,
  input  logic               cfg_parity_en,
  input  logic               cfg_stop2,
  output logic               rts_n,
  output logic               rx_trig_irq,
  output logic               rx_timeout_irq,
  output logic               rts_state
);

  rts_state_t         r_state;
  logic               r_trig_irq;
  logic [LEVEL_W-1:0] w_lo_eff;
  logic [LEVEL_W-1:0] w_trig_eff;
  logic [3:0]         w_char_bits;
  logic [TMO_W-1:0]   w_limit;
  logic               w_clr_cnt;
  logic               w_clr_irq;

  // Keep lo strictly below hi so a single level value cannot toggle RTS.
  always_comb begin
    w_lo_eff = cfg_rts_lo;
    if (cfg_rts_lo >= cfg_rts_hi) begin
      w_lo_eff = (cfg_rts_hi == '0) ? '0 : cfg_rts_hi - LEVEL_W'(1);
    end
  end

  assign w_trig_eff  = (cfg_trig_level == '0) ? LEVEL_W'(1) : cfg_trig_level;
  assign w_char_bits = char_bits(cfg_data_bits, cfg_parity_en, cfg_stop2);
  assign w_limit     = TMO_W'(TIMEOUT_CHARS * OVERSAMPLE_RATE * 32'(w_char_bits));
  assign w_clr_cnt   = rx_wr_pulse | rd_pulse_sync | rx_active | rx_empty_sync;
  assign w_clr_irq   = rx_wr_pulse | rd_pulse_sync;

  // RTS FSM and trigger flag; RTS only reasserts between frames.
  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      r_state    <= RTS_RUN;
      r_trig_irq <= 1'b0;
    end else if (fifo_reset_sync) begin
      r_state    <= RTS_RUN;
      r_trig_irq <= 1'b0;
    end else begin
      r_trig_irq <= (rx_level >= w_trig_eff);
      case (r_state)
        RTS_RUN: begin
          if (cfg_flow_en && (rx_level >= cfg_rts_hi)) begin
            r_state <= RTS_HOLD;
          end
        end
        RTS_HOLD: begin
          if (!cfg_flow_en) begin
            r_state <= RTS_RUN;
          end else if ((rx_level <= w_lo_eff) && !rx_active) begin
            r_state <= RTS_RUN;
          end
        end
        default: r_state <= RTS_RUN;
      endcase
    end
  end

  uart_rx_timeout_cnt #(
    .TMO_W (TMO_W)
  ) u_timeout_cnt (
    .uart_clk     (uart_clk),
    .uart_rst_n   (uart_rst_n),
    .i_fifo_reset (fifo_reset_sync),
    .i_clr_cnt    (w_clr_cnt),
    .i_clr_irq    (w_clr_irq),
    .i_tick       (sample_tick),
    .i_empty      (rx_empty_sync),
    .i_limit      (w_limit),
    .o_irq        (rx_timeout_irq)
  );

  assign rts_n       = (r_state == RTS_HOLD);
  assign rts_state   = r_state;
  assign rx_trig_irq = r_trig_irq;

endmodule

// File: tb/tb_uart_rx_flow_ctrl.sv
// Directed self-checking bench for uart_rx_flow_ctrl.
module tb_uart_rx_flow_ctrl;

  localparam int unsigned LEVEL_W = 4;

  logic               uart_clk = 1'b0;
  logic               uart_rst_n = 1'b0;
  logic               sample_tick = 1'b0;
  logic               rx_active = 1'b0;
  logic               rx_wr_pulse = 1'b0;
  logic [LEVEL_W-1:0] rx_level = '0;
  logic               rx_empty_sync = 1'b1;
  logic               rd_pulse_sync = 1'b0;
  logic               fifo_reset_sync = 1'b0;
  logic               cfg_flow_en = 1'b0;
  logic [LEVEL_W-1:0] cfg_rts_hi = 4'd6;
  logic [LEVEL_W-1:0] cfg_rts_lo = 4'd2;
  logic [LEVEL_W-1:0] cfg_trig_level = 4'd4;
  logic [1:0]         cfg_data_bits = 2'd3;
  logic               cfg_parity_en = 1'b0;
  logic               cfg_stop2 = 1'b0;
  logic               rts_n;
  logic               rx_trig_irq;
  logic               rx_timeout_irq;
  logic               rts_state;

  int checks = 0;
  int errors = 0;

  always #5 uart_clk = ~uart_clk;

  uart_rx_flow_ctrl dut (
    .uart_clk        (uart_clk),
    .uart_rst_n      (uart_rst_n),
    .sample_tick     (sample_tick),
    .rx_active       (rx_active),
    .rx_wr_pulse     (rx_wr_pulse),
    .rx_level        (rx_level),
    .rx_empty_sync   (rx_empty_sync),
    .rd_pulse_sync   (rd_pulse_sync),
    .fifo_reset_sync (fifo_reset_sync),
    .cfg_flow_en     (cfg_flow_en),
    .cfg_rts_hi      (cfg_rts_hi),
    .cfg_rts_lo      (cfg_rts_lo),
    .cfg_trig_level  (cfg_trig_level),
    .cfg_data_bits   (cfg_data_bits),
    .cfg_parity_en   (cfg_parity_en),
    .cfg_stop2       (cfg_stop2),
    .rts_n           (rts_n),
    .rx_trig_irq     (rx_trig_irq),
    .rx_timeout_irq  (rx_timeout_irq),
    .rts_state       (rts_state)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge uart_clk);
      #1;
    end
  endtask

  task automatic test_reset;
    step(2);
    checks++;
    if ({rts_n, rx_trig_irq, rx_timeout_irq, rts_state} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: outs=%b exp=0000", {rts_n, rx_trig_irq, rx_timeout_irq, rts_state});
    end
    #3 uart_rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_rts_hysteresis;
    cfg_flow_en = 1'b1; cfg_rts_hi = 4'd6; cfg_rts_lo = 4'd2; rx_empty_sync = 1'b0;
    for (int l = 1; l <= 5; l++) begin
      rx_level = LEVEL_W'(l); rx_wr_pulse = 1'b1;
      step(1);
    end
    checks++;
    if (rts_n !== 1'b0) begin errors++; $display("FAIL hyst_below_hi: rts_n=%b exp=0", rts_n); end
    rx_level = 4'd6;
    checks++;
    if (rts_n !== 1'b0) begin errors++; $display("FAIL hyst_latency: rts_n=%b exp=0", rts_n); end
    step(1);
    rx_wr_pulse = 1'b0;
    checks++;
    if (rts_n !== 1'b1 || rts_state !== 1'b1) begin
      errors++; $display("FAIL hyst_hold: rts_n=%b state=%b exp=1/1", rts_n, rts_state);
    end
    for (int l = 5; l >= 3; l--) begin
      rx_level = LEVEL_W'(l); rd_pulse_sync = 1'b1;
      step(1);
    end
    checks++;
    if (rts_n !== 1'b1) begin errors++; $display("FAIL hyst_above_lo: rts_n=%b exp=1", rts_n); end
    rx_level = 4'd2;
    step(1);
    rd_pulse_sync = 1'b0;
    checks++;
    if (rts_n !== 1'b0 || rts_state !== 1'b0) begin
      errors++; $display("FAIL hyst_release: rts_n=%b state=%b exp=0/0", rts_n, rts_state);
    end
  endtask

  task automatic test_rts_mid_frame;
    rx_level = 4'd6;
    step(1);
    rx_active = 1'b1; rx_level = 4'd2;
    step(3);
    checks++;
    if (rts_n !== 1'b1) begin errors++; $display("FAIL mid_frame_hold: rts_n=%b exp=1", rts_n); end
    rx_active = 1'b0;
    step(1);
    checks++;
    if (rts_n !== 1'b0) begin errors++; $display("FAIL mid_frame_release: rts_n=%b exp=0", rts_n); end
  endtask

  task automatic test_lo_ge_hi;
    cfg_rts_hi = 4'd4; cfg_rts_lo = 4'd5; rx_level = 4'd4;
    step(1);
    checks++;
    if (rts_n !== 1'b1) begin errors++; $display("FAIL lohi_hold: rts_n=%b exp=1", rts_n); end
    step(3);
    checks++;
    if (rts_n !== 1'b1) begin errors++; $display("FAIL lohi_no_osc: rts_n=%b exp=1", rts_n); end
    rx_level = 4'd3;
    step(1);
    checks++;
    if (rts_n !== 1'b0) begin errors++; $display("FAIL lohi_release: rts_n=%b exp=0", rts_n); end
    rx_level = 4'd5;
    step(1);
    cfg_flow_en = 1'b0;
    step(1);
    checks++;
    if (rts_n !== 1'b0) begin errors++; $display("FAIL flow_disable: rts_n=%b exp=0", rts_n); end
    cfg_rts_hi = 4'd6; cfg_rts_lo = 4'd2;
  endtask

  task automatic test_trigger;
    cfg_trig_level = 4'd4; rx_level = 4'd3;
    step(1);
    checks++;
    if (rx_trig_irq !== 1'b0) begin errors++; $display("FAIL trig_l3: irq=%b exp=0", rx_trig_irq); end
    rx_level = 4'd4;
    step(1);
    checks++;
    if (rx_trig_irq !== 1'b1) begin errors++; $display("FAIL trig_l4: irq=%b exp=1", rx_trig_irq); end
    cfg_trig_level = 4'd0; rx_level = 4'd0;
    step(1);
    checks++;
    if (rx_trig_irq !== 1'b0) begin errors++; $display("FAIL trig0_l0: irq=%b exp=0", rx_trig_irq); end
    rx_level = 4'd1;
    step(1);
    checks++;
    if (rx_trig_irq !== 1'b1) begin errors++; $display("FAIL trig0_l1: irq=%b exp=1", rx_trig_irq); end
    cfg_trig_level = 4'd4;
  endtask

  task automatic test_timeout_8n1;
    cfg_data_bits = 2'd3; rx_level = 4'd1; rx_empty_sync = 1'b0;
    rx_wr_pulse = 1'b1;
    step(1);
    rx_wr_pulse = 1'b0; sample_tick = 1'b1;
    step(639);
    checks++;
    if (rx_timeout_irq !== 1'b0) begin errors++; $display("FAIL tmo8_639: irq=%b exp=0", rx_timeout_irq); end
    step(1);
    checks++;
    if (rx_timeout_irq !== 1'b0) begin errors++; $display("FAIL tmo8_640: irq=%b exp=0", rx_timeout_irq); end
    step(1);
    checks++;
    if (rx_timeout_irq !== 1'b1) begin errors++; $display("FAIL tmo8_641: irq=%b exp=1", rx_timeout_irq); end
    sample_tick = 1'b0; rx_active = 1'b1;
    step(3);
    rx_active = 1'b0;
    checks++;
    if (rx_timeout_irq !== 1'b1) begin errors++; $display("FAIL tmo8_sticky: irq=%b exp=1", rx_timeout_irq); end
    rd_pulse_sync = 1'b1;
    step(1);
    rd_pulse_sync = 1'b0;
    checks++;
    if (rx_timeout_irq !== 1'b0) begin errors++; $display("FAIL tmo8_rd_clear: irq=%b exp=0", rx_timeout_irq); end
  endtask

  task automatic test_timeout_5n1;
    cfg_data_bits = 2'd0; sample_tick = 1'b1;
    step(300);
    rx_wr_pulse = 1'b1;
    step(1);
    rx_wr_pulse = 1'b0;
    step(447);
    checks++;
    if (rx_timeout_irq !== 1'b0) begin errors++; $display("FAIL tmo5_wr_restart: irq=%b exp=0", rx_timeout_irq); end
    step(1);
    checks++;
    if (rx_timeout_irq !== 1'b0) begin errors++; $display("FAIL tmo5_448: irq=%b exp=0", rx_timeout_irq); end
    step(1);
    checks++;
    if (rx_timeout_irq !== 1'b1) begin errors++; $display("FAIL tmo5_449: irq=%b exp=1", rx_timeout_irq); end
    rd_pulse_sync = 1'b1;
    step(1);
    rd_pulse_sync = 1'b0; cfg_data_bits = 2'd3;
    step(500);
    checks++;
    if (rx_timeout_irq !== 1'b0) begin errors++; $display("FAIL tmo_cfg_before: irq=%b exp=0", rx_timeout_irq); end
    cfg_data_bits = 2'd0;
    step(1);
    checks++;
    if (rx_timeout_irq !== 1'b1) begin errors++; $display("FAIL tmo_cfg_shrink: irq=%b exp=1", rx_timeout_irq); end
    rx_wr_pulse = 1'b1; rd_pulse_sync = 1'b1;
    step(1);
    rx_wr_pulse = 1'b0; rd_pulse_sync = 1'b0;
    checks++;
    if (rx_timeout_irq !== 1'b0) begin errors++; $display("FAIL tmo_wr_rd_both: irq=%b exp=0", rx_timeout_irq); end
    rx_empty_sync = 1'b1;
    step(1000);
    checks++;
    if (rx_timeout_irq !== 1'b0) begin errors++; $display("FAIL tmo_empty: irq=%b exp=0", rx_timeout_irq); end
  endtask

  task automatic test_fifo_reset;
    cfg_flow_en = 1'b1; cfg_trig_level = 4'd4; rx_level = 4'd7; rx_empty_sync = 1'b0;
    step(450);
    checks++;
    if ({rts_n, rx_trig_irq, rx_timeout_irq} !== 3'b111) begin
      errors++; $display("FAIL frst_setup: outs=%b exp=111", {rts_n, rx_trig_irq, rx_timeout_irq});
    end
    fifo_reset_sync = 1'b1;
    step(1);
    checks++;
    if ({rts_n, rx_trig_irq, rx_timeout_irq, rts_state} !== 4'b0000) begin
      errors++; $display("FAIL frst_clear: outs=%b exp=0000", {rts_n, rx_trig_irq, rx_timeout_irq, rts_state});
    end
    fifo_reset_sync = 1'b0; rx_level = 4'd1;
    step(447);
    checks++;
    if ({rts_n, rx_trig_irq, rx_timeout_irq} !== 3'b000) begin
      errors++; $display("FAIL frst_cnt_zero: outs=%b exp=000", {rts_n, rx_trig_irq, rx_timeout_irq});
    end
    step(2);
    checks++;
    if (rx_timeout_irq !== 1'b1) begin errors++; $display("FAIL frst_recount: irq=%b exp=1", rx_timeout_irq); end
  endtask

  task automatic test_async_reset;
    rx_level = 4'd7;
    step(1);
    rx_wr_pulse = 1'b1;
    step(1);
    rx_wr_pulse = 1'b0;
    step(100);
    #3 uart_rst_n = 1'b0;
    #1;
    checks++;
    if ({rts_n, rx_trig_irq, rx_timeout_irq, rts_state} !== 4'b0000) begin
      errors++; $display("FAIL async_rst_now: outs=%b exp=0000", {rts_n, rx_trig_irq, rx_timeout_irq, rts_state});
    end
    step(2);
    checks++;
    if ({rts_n, rx_trig_irq, rx_timeout_irq, rts_state} !== 4'b0000) begin
      errors++; $display("FAIL async_rst_hold: outs=%b exp=0000", {rts_n, rx_trig_irq, rx_timeout_irq, rts_state});
    end
    sample_tick = 1'b0; rx_level = 4'd0; rx_empty_sync = 1'b1;
    #3 uart_rst_n = 1'b1;
    step(2);
    checks++;
    if ({rts_n, rx_trig_irq, rx_timeout_irq} !== 3'b000) begin
      errors++; $display("FAIL async_rst_after: outs=%b exp=000", {rts_n, rx_trig_irq, rx_timeout_irq});
    end
  endtask

  initial begin
    test_reset();
    test_rts_hysteresis();
    test_rts_mid_frame();
    test_lo_ge_hi();
    test_trigger();
    test_timeout_8n1();
    test_timeout_5n1();
    test_fifo_reset();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
